// File: rtl/snake_game_ctrl.sv
// Game-sequencing controller for the snake display datapath.
// Decodes PS/2 make codes into game commands, runs the BLACK/INIT/RUN/PAUSE/DEAD
// state machine, and paces snake movement from the frame strobe as one-cycle
// step pulses carrying a committed direction.
module snake_game_ctrl #(
  parameter int unsigned FRAMES_PER_STEP  = 6,
  parameter int unsigned DEAD_HOLD_FRAMES = 120
) (
  input  logic        clk25,
  input  logic        rst,
  input  logic        frame_tick,
  input  logic        key_valid,
  input  logic [7:0]  key_code,
  input  logic        died,
  output logic        init_snake,
  output logic        step,
  output logic [1:0]  dir,
  output logic        screen_black,
  output logic        screen_pause,
  output logic [2:0]  state,
  output logic [15:0] step_count
);

  typedef enum logic [2:0] {
    S_BLACK = 3'd0,
    S_INIT  = 3'd1,
    S_RUN   = 3'd2,
    S_PAUSE = 3'd3,
    S_DEAD  = 3'd4
  } state_t;

  localparam logic [7:0] K_RIGHT = 8'h74;
  localparam logic [7:0] K_LEFT  = 8'h6B;
  localparam logic [7:0] K_DOWN  = 8'h72;
  localparam logic [7:0] K_UP    = 8'h75;
  localparam logic [7:0] K_SPACE = 8'h29;
  localparam logic [7:0] K_PAUSE = 8'h4D;
  localparam logic [7:0] K_ESC   = 8'h76;

  localparam logic [7:0] STEP_LAST = 8'(FRAMES_PER_STEP - 1);
  localparam logic [7:0] DEAD_LAST = 8'(DEAD_HOLD_FRAMES - 1);

  state_t      cur_state;
  state_t      nxt_state;
  logic [7:0]  frame_cnt;
  logic [1:0]  pend_dir;

  logic        k_space;
  logic        k_pause;
  logic        k_esc;
  logic        k_arrow;
  logic [1:0]  arrow_dir;
  logic        step_hit;
  logic [1:0]  dir_after;
  logic        arrow_ok;

  assign state = cur_state;

  // Key decode: one command flag per recognised make code; unknown codes fall through.
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    k_space   = 1'b0;
    k_pause   = 1'b0;
    k_esc     = 1'b0;
    k_arrow   = 1'b0;
    arrow_dir = 2'b00;
    if (key_valid) begin
      case (key_code)
        K_RIGHT: begin k_arrow = 1'b1; arrow_dir = 2'b00; end
        K_LEFT:  begin k_arrow = 1'b1; arrow_dir = 2'b01; end
        K_DOWN:  begin k_arrow = 1'b1; arrow_dir = 2'b10; end
        K_UP:    begin k_arrow = 1'b1; arrow_dir = 2'b11; end
        K_SPACE: k_space = 1'b1;
        K_PAUSE: k_pause = 1'b1;
        K_ESC:   k_esc   = 1'b1;
        default: ;
      endcase
    end
  end

  // Next-state and step qualification; died outranks Esc, P and arrows in RUN.
  always_comb begin
    step_hit  = (cur_state == S_RUN) && !died && frame_tick && (frame_cnt == STEP_LAST);
    // An arrow arriving with a step is judged against the direction just committed.
    dir_after = step_hit ? pend_dir : dir;
    // Reverse pairs differ only in bit 0 (right/left, down/up).
    arrow_ok  = k_arrow && (arrow_dir != (dir_after ^ 2'b01));
    nxt_state = cur_state;
    case (cur_state)
      S_BLACK: if (k_space) nxt_state = S_INIT;
      S_INIT:  nxt_state = S_RUN;
      S_RUN: begin
        if (died)         nxt_state = S_DEAD;
        else if (k_esc)   nxt_state = S_BLACK;
        else if (k_pause) nxt_state = S_PAUSE;
      end
      S_PAUSE: begin
        if (k_esc)        nxt_state = S_BLACK;
        else if (k_pause) nxt_state = S_RUN;
      end
      S_DEAD: begin
        if (k_space)      nxt_state = S_INIT;
        else if (k_esc)   nxt_state = S_BLACK;
        else if (frame_tick && (frame_cnt == DEAD_LAST)) nxt_state = S_BLACK;
      end
      default:            nxt_state = S_BLACK;
    endcase
  end

  // State, counters, direction and registered output decode.
  always_ff @(posedge clk25) begin
    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    if (rst) begin
      cur_state    <= S_BLACK;
      frame_cnt    <= 8'd0;
      pend_dir     <= 2'b00;
      dir          <= 2'b00;
      step_count   <= 16'd0;
      step         <= 1'b0;
      init_snake   <= 1'b0;
      screen_black <= 1'b1;
      screen_pause <= 1'b0;
    end else begin
      cur_state    <= nxt_state;
      step         <= step_hit;
      init_snake   <= (nxt_state == S_INIT);
      screen_black <= (nxt_state == S_BLACK);
      screen_pause <= (nxt_state == S_PAUSE) || (nxt_state == S_DEAD);

      if (step_hit) begin
        dir        <= pend_dir;
        step_count <= step_count + 16'd1;
      end

      case (cur_state)
        S_RUN: begin
          if (died) begin
            frame_cnt <= 8'd0;
          end else begin
            if (frame_tick) frame_cnt <= step_hit ? 8'd0 : frame_cnt + 8'd1;
            if (arrow_ok)   pend_dir  <= arrow_dir;
          end
        end
        S_DEAD: begin
          if (frame_tick) frame_cnt <= (frame_cnt == DEAD_LAST) ? 8'd0 : frame_cnt + 8'd1;
        end
        S_PAUSE: ;
        default: frame_cnt <= 8'd0;
      endcase

      // Entering INIT resets the game so the INIT cycle already shows a fresh snake state.
      if (nxt_state == S_INIT) begin
        dir        <= 2'b00;
        pend_dir   <= 2'b00;
        frame_cnt  <= 8'd0;
        step_count <= 16'd0;
      end
    end
  end

endmodule

// File: tb/tb_snake_game_ctrl.sv
// Self-checking bench for snake_game_ctrl: a vector table for the start-up
// sequence, then hand-written sequences for direction, pause, death and reset.
module tb_snake_game_ctrl;

  localparam logic [7:0] K_RIGHT = 8'h74;
  localparam logic [7:0] K_LEFT  = 8'h6B;
  localparam logic [7:0] K_DOWN  = 8'h72;
  localparam logic [7:0] K_UP    = 8'h75;
  localparam logic [7:0] K_SPACE = 8'h29;
  localparam logic [7:0] K_PAUSE = 8'h4D;
  localparam logic [7:0] K_ESC   = 8'h76;

  localparam logic [2:0] ST_BLACK = 3'd0;
  localparam logic [2:0] ST_INIT  = 3'd1;
  localparam logic [2:0] ST_RUN   = 3'd2;
  localparam logic [2:0] ST_PAUSE = 3'd3;
  localparam logic [2:0] ST_DEAD  = 3'd4;

  logic        clk25 = 1'b0;
  logic        rst = 1'b0;
  logic        frame_tick = 1'b0;
  logic        key_valid = 1'b0;
  logic [7:0]  key_code = 8'h00;
  logic        died = 1'b0;
  logic        init_snake;
  logic        step;
  logic [1:0]  dir;
  logic        screen_black;
  logic        screen_pause;
  logic [2:0]  state;
  logic [15:0] step_count;

  int passed = 0;
  int total  = 0;
  int steps_seen = 0;

  typedef struct {
    logic        tick;
    logic        kv;
    logic [7:0]  code;
    logic [2:0]  exp_state;
    logic        exp_init;
    logic        exp_step;
    logic [1:0]  exp_dir;
    logic [15:0] exp_cnt;
  } vec_t;

  vec_t vecs [15];

  snake_game_ctrl #(.FRAMES_PER_STEP(6), .DEAD_HOLD_FRAMES(120)) dut (
    .clk25        (clk25),
    .rst          (rst),
    .frame_tick   (frame_tick),
    .key_valid    (key_valid),
    .key_code     (key_code),
    .died         (died),
    .init_snake   (init_snake),
    .step         (step),
    .dir          (dir),
    .screen_black (screen_black),
    .screen_pause (screen_pause),
    .state        (state),
    .step_count   (step_count)
  );

  always #20 clk25 = ~clk25;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    else passed++;
  endtask

  // Drive one cycle of inputs at a falling edge; outputs are stable at the next falling edge.
  task automatic cyc(input logic t, input logic kv, input logic [7:0] code,
                     input logic d, input logic r);
    frame_tick = t;
    key_valid  = kv;
    key_code   = code;
    died       = d;
    rst        = r;
    @(negedge clk25);
    frame_tick = 1'b0;
    key_valid  = 1'b0;
    key_code   = 8'h00;
    died       = 1'b0;
    rst        = 1'b0;
    if (step) steps_seen++;
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic key(input logic [7:0] code);
    cyc(1'b0, 1'b1, code, 1'b0, 1'b0);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  // Issue frame ticks until a step pulse appears; returns ticks used, bounded.
  task automatic run_to_step(input string name, input int exp_ticks);
    int n;
    n = 0;
    while (n < 20) begin
      cyc(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
      n++;
      if (step) break;
    end
    check({name, " ticks_to_step"}, n, exp_ticks);
    check({name, " step"}, {31'd0, step}, 32'd1);
  endtask

  initial begin
    // Start-up: space, one INIT cycle, then 13 ticks with steps at the 6th and 12th.
    vecs[0]  = '{1'b0, 1'b1, K_SPACE, ST_INIT, 1'b1, 1'b0, 2'b00, 16'd0};
    vecs[1]  = '{1'b0, 1'b0, 8'h00,   ST_RUN,  1'b0, 1'b0, 2'b00, 16'd0};
    vecs[2]  = '{1'b1, 1'b0, 8'h00,   ST_RUN,  1'b0, 1'b0, 2'b00, 16'd0};
    vecs[3]  = '{1'b1, 1'b0, 8'h00,   ST_RUN,  1'b0, 1'b0, 2'b00, 16'd0};
    vecs[4]  = '{1'b1, 1'b0, 8'h00,   ST_RUN,  1'b0, 1'b0, 2'b00, 16'd0};
    vecs[5]  = '{1'b1, 1'b0, 8'h00,   ST_RUN,  1'b0, 1'b0, 2'b00, 16'd0};
    vecs[6]  = '{1'b1, 1'b0, 8'h00,   ST_RUN,  1'b0, 1'b0, 2'b00, 16'd0};
    vecs[7]  = '{1'b1, 1'b0, 8'h00,   ST_RUN,  1'b0, 1'b1, 2'b00, 16'd1};
    vecs[8]  = '{1'b1, 1'b0, 8'h00,   ST_RUN,  1'b0, 1'b0, 2'b00, 16'd1};
    vecs[9]  = '{1'b1, 1'b0, 8'h00,   ST_RUN,  1'b0, 1'b0, 2'b00, 16'd1};
    vecs[10] = '{1'b1, 1'b0, 8'h00,   ST_RUN,  1'b0, 1'b0, 2'b00, 16'd1};
    vecs[11] = '{1'b1, 1'b0, 8'h00,   ST_RUN,  1'b0, 1'b0, 2'b00, 16'd1};
    vecs[12] = '{1'b1, 1'b0, 8'h00,   ST_RUN,  1'b0, 1'b0, 2'b00, 16'd1};
    vecs[13] = '{1'b1, 1'b0, 8'h00,   ST_RUN,  1'b0, 1'b1, 2'b00, 16'd2};
    vecs[14] = '{1'b1, 1'b0, 8'h00,   ST_RUN,  1'b0, 1'b0, 2'b00, 16'd2};

    @(negedge clk25);
    cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    check("reset state", state, ST_BLACK);
    check("reset screen_black", screen_black, 1);
    check("reset screen_pause", screen_pause, 0);
    check("reset step_count", step_count, 0);

    // Unknown key and arrows are ignored in BLACK.
    key(K_UP);
    key(8'h1C);
    check("black ignores keys", state, ST_BLACK);

    steps_seen = 0;
    for (int i = 0; i < 15; i++) begin
      cyc(vecs[i].tick, vecs[i].kv, vecs[i].code, 1'b0, 1'b0);
      check($sformatf("vec%0d state", i), state, vecs[i].exp_state);
      check($sformatf("vec%0d init_snake", i), init_snake, vecs[i].exp_init);
      check($sformatf("vec%0d step", i), step, vecs[i].exp_step);
      check($sformatf("vec%0d dir", i), dir, vecs[i].exp_dir);
      check($sformatf("vec%0d step_count", i), step_count, vecs[i].exp_cnt);
    end
    check("startup step pulses", steps_seen, 2);

    // Direction rules: reverse rejected, last accepted arrow committed at next step.
    key(K_LEFT);
    key(K_DOWN);
    check("dir before step", dir, 2'b00);
    run_to_step("down", 5);
    check("dir down", dir, 2'b10);
    check("count after down", step_count, 3);
    key(K_UP);
    run_to_step("up rejected", 6);
    check("dir still down", dir, 2'b10);
    key(K_LEFT);
    run_to_step("left", 6);
    check("dir left", dir, 2'b01);
    check("count after left", step_count, 5);

    // Pause holds the frame counter; resume continues from it.
    ticks(3);
    key(K_PAUSE);
    check("paused state", state, ST_PAUSE);
    check("paused screen_pause", screen_pause, 1);
    steps_seen = 0;
    ticks(10);
    cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    key(K_RIGHT);
    check("no step in pause", steps_seen, 0);
    check("pause ignores died", state, ST_PAUSE);
    key(K_PAUSE);
    check("resumed", state, ST_RUN);
    check("resume screen_pause", screen_pause, 0);
    run_to_step("resume", 3);
    check("dir after resume", dir, 2'b01);
    check("count after resume", step_count, 6);

    // died coincident with the qualifying tick suppresses the step.
    ticks(5);
    cyc(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
    check("dead state", state, ST_DEAD);
    check("dead no step", step, 0);
    check("dead count", step_count, 6);
    check("dead dir", dir, 2'b01);
    check("dead screen_pause", screen_pause, 1);
    ticks(119);
    check("dead hold 119", state, ST_DEAD);
    ticks(1);
    check("dead hold done", state, ST_BLACK);
    check("dead to black screen", screen_black, 1);
    check("black screen_pause", screen_pause, 0);

    // Restart from DEAD with space, then quit with Esc.
    key(K_SPACE);
    idle();
    run_to_step("restart", 6);
    key(K_DOWN);
    run_to_step("restart down", 6);
    check("restart dir", dir, 2'b10);
    check("restart count", step_count, 2);
    cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    check("dead again", state, ST_DEAD);
    ticks(5);
    key(K_SPACE);
    check("dead space init", init_snake, 1);
    check("dead space state", state, ST_INIT);
    check("dead space count", step_count, 0);
    check("dead space dir", dir, 2'b00);
    idle();
    check("init one cycle", state, ST_RUN);
    check("init pulse ends", init_snake, 0);
    key(K_ESC);
    check("esc black", state, ST_BLACK);
    check("esc screen_black", screen_black, 1);

    // Reset while paused with seven steps taken.
    key(K_SPACE);
    idle();
    for (int i = 0; i < 7; i++) run_to_step($sformatf("pre-reset %0d", i), 6);
    key(K_PAUSE);
    check("pre-reset count", step_count, 7);
    check("pre-reset state", state, ST_PAUSE);
    cyc(1'b1, 1'b1, K_PAUSE, 1'b1, 1'b1);
    check("rst state", state, ST_BLACK);
    check("rst screen_black", screen_black, 1);
    check("rst screen_pause", screen_pause, 0);
    check("rst init_snake", init_snake, 0);
    check("rst step", step, 0);
    check("rst dir", dir, 2'b00);
    check("rst step_count", step_count, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
